// File: rtl/csa_serial_accumulator.sv
// Streaming multi-operand adder: operands are folded into a carry-save pair one
// per handshake, then the redundant pair is carry-resolved into a binary result.
module csa_serial_accumulator #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned NUM_OPS   = 9,
   parameter int unsigned OUT_WIDTH = 21
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_sum,
   output logic                 busy
);

   localparam int unsigned CNT_W = $clog2(NUM_OPS + 1);
   localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(NUM_OPS - 1);

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [OUT_WIDTH-1:0]  r_s, w_s_nxt;
   logic [OUT_WIDTH-1:0]  r_c, w_c_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic                  r_out_valid, w_out_valid_nxt;
   logic [OUT_WIDTH-1:0]  r_out_sum, w_out_sum_nxt;
   logic                  r_in_ready, w_in_ready_nxt;
   logic                  r_busy, w_busy_nxt;

   logic [OUT_WIDTH-1:0]  w_x;
   logic [OUT_WIDTH-1:0]  w_maj;
   logic [OUT_WIDTH-1:0]  w_gen;

   assign w_x   = OUT_WIDTH'(in_data);
   assign w_maj = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);
   assign w_gen = r_s & r_c;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_ACCUM;
         r_s         <= '0;
         r_c         <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_s         <= w_s_nxt;
         r_c         <= w_c_nxt;
         r_cnt       <= w_cnt_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_sum   <= w_out_sum_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   // Next-state and datapath update
   always_comb begin
      w_state_nxt     = r_state;
      w_s_nxt         = r_s;
      w_c_nxt         = r_c;
      w_cnt_nxt       = r_cnt;
      w_out_valid_nxt = r_out_valid;
      w_out_sum_nxt   = r_out_sum;

      unique case (r_state)
         ST_ACCUM: begin
            if (in_valid) begin
               // One 3:2 compressor layer per accepted operand
               w_s_nxt = r_s ^ r_c ^ w_x;
               w_c_nxt = {w_maj[OUT_WIDTH-2:0], 1'b0};
               if (r_cnt == LAST_OP) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_RESOLVE;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         ST_RESOLVE: begin
            if (r_c == '0) begin
               w_out_sum_nxt   = r_s;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = ST_DONE;
            end else begin
               w_s_nxt = r_s ^ r_c;
               w_c_nxt = {w_gen[OUT_WIDTH-2:0], 1'b0};
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_s_nxt         = '0;
               w_c_nxt         = '0;
               w_state_nxt     = ST_ACCUM;
            end
         end
         default: begin
            w_state_nxt = ST_ACCUM;
         end
      endcase

      // Handshake flags are registered from the upcoming state
      w_in_ready_nxt = (w_state_nxt == ST_ACCUM);
      w_busy_nxt     = (w_state_nxt != ST_ACCUM);
   end

   assign in_ready  = r_in_ready;
   assign busy      = r_busy;
   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;

endmodule

// File: tb/tb_csa_serial_accumulator.sv
// Randomized and directed bench for csa_serial_accumulator; a per-cycle monitor
// compares the DUT against a transaction-level sum model.
module tb_csa_serial_accumulator;

   localparam int unsigned WIDTH     = 16;
   localparam int unsigned NUM_OPS   = 9;
   localparam int unsigned OUT_WIDTH = 21;
   localparam longint      MODMASK   = (longint'(1) << OUT_WIDTH) - 1;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_sum;
   logic                 busy;

   int n_chk  = 0;
   int n_pass = 0;

   // model: 0 = collecting operands, 1 = awaiting result, 2 = result presented
   int     m_phase    = 0;
   int     m_cnt      = 0;
   longint m_acc      = 0;
   longint m_new_res  = 0;
   longint m_prev_res = 0;
   int     m_wait     = 0;
   int     m_lat      = 0;
   int     m_results  = 0;

   csa_serial_accumulator #(
      .WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .OUT_WIDTH(OUT_WIDTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
   endtask

   // Per-cycle compare, then advance the model for the coming rising edge
   always @(negedge clk) begin
      if (!rst_n) begin
         m_phase = 0; m_cnt = 0; m_acc = 0; m_new_res = 0; m_prev_res = 0; m_wait = 0;
      end else begin
         chk("in_ready", in_ready, (m_phase == 0) ? 1 : 0);
         chk("busy", busy, (m_phase != 0) ? 1 : 0);
         case (m_phase)
            0: begin
               chk("out_valid_idle", out_valid, 0);
               chk("out_sum_hold", out_sum, m_prev_res);
            end
            1: begin
               if (out_valid) begin
                  chk("out_sum_result", out_sum, m_new_res);
                  m_prev_res = m_new_res;
                  m_lat      = m_wait;
                  m_phase    = 2;
                  m_results++;
               end else begin
                  chk("out_sum_hold_resolve", out_sum, m_prev_res);
                  m_wait++;
                  if (m_wait > OUT_WIDTH + 1) begin
                     chk("resolve_latency_bound", m_wait, OUT_WIDTH + 1);
                     m_phase = 0;
                  end
               end
            end
            default: begin
               chk("out_valid_done", out_valid, 1);
               chk("out_sum_done", out_sum, m_prev_res);
            end
         endcase
         if (m_phase == 0 && in_valid) begin
            m_acc += longint'(in_data);
            m_cnt++;
            if (m_cnt == NUM_OPS) begin
               m_new_res = m_acc & MODMASK;
               m_acc     = 0;
               m_cnt     = 0;
               m_wait    = 0;
               m_phase   = 1;
            end
         end else if (m_phase == 2 && out_ready) begin
            m_phase = 0;
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] x);
      int t = 0;
      in_valid = 1'b1;
      in_data  = x;
      while (!in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) chk("in_ready_timeout", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
   endtask

   task automatic wait_result();
      int t = 0;
      while (!out_valid && t < 40) begin
         @(posedge clk); #1;
         t++;
      end
      if (!out_valid) chk("out_valid_timeout", out_valid, 1);
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
   endtask

   logic [WIDTH-1:0] ops1 [NUM_OPS] = '{16'd2, 16'd3, 16'd4, 16'd12261, 16'd2467,
                                        16'd8067, 16'd13767, 16'd35633, 16'd943};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_sum", out_sum, 0);
      rst_n = 1'b1;

      // Back-to-back reference operands
      foreach (ops1[i]) send(ops1[i]);
      wait_result();
      chk("t1_sum", out_sum, 73147);
      chk("t1_latency_bound", (m_lat >= 1 && m_lat <= OUT_WIDTH + 1) ? 1 : 0, 1);
      take();

      // All-ones operands: no wrap at the output width
      for (int i = 0; i < NUM_OPS; i++) send(16'hFFFF);
      wait_result();
      chk("t2_sum", out_sum, 589815);
      take();

      // Zeros: carry is already clear, resolution takes one cycle
      for (int i = 0; i < NUM_OPS; i++) send(16'h0000);
      wait_result();
      chk("t3_sum", out_sum, 0);
      chk("t3_latency", m_lat, 1);
      take();

      // Gapped operands, then garbage offered while resolving and presenting
      foreach (ops1[i]) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         send(ops1[i]);
      end
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      wait_result();
      chk("t4_sum", out_sum, 73147);

      // Backpressure while the result is presented
      for (int k = 0; k < 5; k++) begin
         chk("t5_out_valid", out_valid, 1);
         chk("t5_in_ready", in_ready, 0);
         chk("t5_out_sum", out_sum, 73147);
         @(posedge clk); #1;
      end
      take();
      chk("t5_in_ready_after", in_ready, 1);
      chk("t5_out_sum_kept", out_sum, 73147);

      // Asynchronous reset in the middle of an accumulation
      for (int i = 0; i < 4; i++) send(16'd1000);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_rst_out_sum", out_sum, 0);
      chk("t6_rst_in_ready", in_ready, 1);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_out_valid", out_valid, 0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_OPS; i++) send(16'd1);
      wait_result();
      chk("t6_sum", out_sum, 9);
      take();

      // Randomized traffic with random valid gaps and random backpressure
      for (int cyc = 0; cyc < 2000; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : WIDTH'($urandom);
         out_ready = ($urandom_range(0, 2) == 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk("random_results_seen", (m_results > 20) ? 1 : 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
